stream_dequantizer_pipe: RTL and testbench
==========================================

// Module: stream_dequantizer_pipe
// PURPOSE
//  Pipelined streaming successor of the one-cycle parallel de-quantizer. Accepts one packed L2 block
//  per handshake and unpacks in_count fixed-width fields, one per cycle. Each field is de-quantized
//  (Mid offset, leading-one normalise, StepSizeExp scaling) or passed through as an integer.
//  Outliers are escape-coded in-band. Output is a valid/ready word stream with backpressure.
// PARAMETERS
//  L2_WIDTH    512  packed block width, bits
//  SWIDTH      5    width of field-width input; fields are 0..31 bits
//  WORD_WIDTH  32   output word: sign[W-1], exponent[W-2:24], mantissa[23:0]
//  EXP_WIDTH   8    step-size exponent width
//  CNT_WIDTH   9    field-count width
//  PTR_WIDTH   derived, clog2(L2_WIDTH)+1; bit-pointer width
// PORTS
//  clk          in   1          clock
//  rst          in   1          synchronous reset, active-high
//  in_valid     in   1          block present
//  in_ready     out  1          block accepted on an edge where in_valid & in_ready
//  in_block     in   L2_WIDTH   packed fields, field 0 at bit 0
//  in_field_w   in   SWIDTH     field width in bits
//  in_count     in   CNT_WIDTH  number of values in block
//  in_mid       in   WORD_WIDTH Mid offset (two's complement)
//  in_step_exp  in   EXP_WIDTH  step-size exponent
//  in_conv      in   1          1 = float de-quantize, 0 = integer passthrough
//  out_valid    out  1          out_data valid
//  out_ready    in   1          consumer accepts word
//  out_data     out  WORD_WIDTH reconstructed word
//  out_outlier  out  1          word came from an escape (raw) slot
//  out_last     out  1          final word of its block
//  busy         out  1          FSM not IDLE, or any pipeline stage valid
// BEHAVIOUR
//  Reset: FSM=IDLE, all stage valids 0, out_valid/out_data/out_outlier/out_last = 0, in_ready = 0 while rst=1.
//  FSM IDLE: in_ready = 1. On accept, capture block, field_w, count, mid, step_exp and conv, and set ptr = 0.
//   count = 0: block is dropped, no output, stay IDLE. Otherwise go to UNPACK.
//  FSM UNPACK, per advancing cycle: f = block[ptr +: field_w]. Bits beyond L2_WIDTH read as 0.
//   - f all-ones and field_w > 0 is the escape: raw = block[ptr+field_w +: 32], outlier = 1,
//     ptr += field_w + 32.
//   - Otherwise ptr += field_w.
//   - The last of the count values drives IDLE on the same edge. The next block may be accepted
//     while the pipeline drains.
//  Pipeline: S0 extract -> S1 add -> S2 format/out register.
//   - Each stage carries conv, mid, step_exp, outlier and last with its data, so back-to-back blocks never mix.
//   - First out_valid occurs 3 cycles after the accepting edge, then 1 word/cycle.
//   - Global stall when out_valid & !out_ready: FSM, ptr and all stages hold, and out_* stay stable.
//  S1:
//   - conv=0: val = zero-extended f.
//   - conv=1: val = in_mid + sign-extended f, mod 2^WORD_WIDTH.
//   - Outlier: val = raw, unchanged.
//  S2, non-outlier with conv=1:
//   - sign = val[W-1]; mag = |val|; p = leading-one index of mag.
//   - exponent = (step_exp + p) mod 2^(W-25).
//   - mantissa = mag bits below p, left-aligned into [23:0]. Excess low bits are truncated.
//   - mag = 0 gives out_data = 0.
//   - conv=0 or outlier: out_data = val.
//  field_w = 0: f = 0, no escape; each value is just Mid converted.
//  Reset asserted mid-block: block is discarded, no further outputs, in_ready = 1 on the first edge after release.
// TESTING
//  1) conv=0, w=4, count=3, block[11:0]=12'h321 -> out 1,2,3 one per cycle, first 3 cycles after accept,
//     out_last on 3.
//  2) conv=1, mid=0x10, step=8, w=4, f=4'h3 -> 0x0C300000; mid=0, f=4'hE -> 0x89000000.
//  3) w=4, block = {32'hDEADBEEF, 4'hF, 4'h5}, count=2 -> 0x5 (outlier=0), then 0xDEADBEEF (outlier=1, last).
//  4) count=8, out_ready low 5 cycles after 2nd word -> out_data held, all 8 words in order, none lost or duplicated.
//  5) back-to-back blocks A (conv=1), count=0 block, B (conv=0) -> A words float, no output for empty block,
//     B words integer, no gap beyond FSM turnaround.
//  6) rst pulsed during UNPACK with 3 words in flight -> out_valid=0 next cycle, busy=0, in_ready=1 after release.

Source files
------------

// File: rtl/stream_dequantizer_pipe_if.sv
// Handshake/bus bundle for stream_dequantizer_pipe.
//  Block side : in_valid/in_ready plus the block payload (block, field width,
//               count, Mid, step exponent, conversion mode).
//  Word side  : out_valid/out_ready plus out_data, out_outlier, out_last.
//  master : producer of blocks and consumer of words (drives in_*, out_ready)
//  slave  : the de-quantizer (drives in_ready, out_*)
interface stream_dequantizer_pipe_if #(
  parameter int L2_WIDTH   = 512,
  parameter int SWIDTH     = 5,
  parameter int WORD_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 9
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [L2_WIDTH-1:0]   in_block;
  logic [SWIDTH-1:0]     in_field_w;
  logic [CNT_WIDTH-1:0]  in_count;
  logic [WORD_WIDTH-1:0] in_mid;
  logic [EXP_WIDTH-1:0]  in_step_exp;
  logic                  in_conv;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_outlier;
  logic                  out_last;

  modport master (
    output in_valid, in_block, in_field_w, in_count, in_mid, in_step_exp, in_conv, out_ready,
    input  in_ready, out_valid, out_data, out_outlier, out_last
  );

  modport slave (
    input  in_valid, in_block, in_field_w, in_count, in_mid, in_step_exp, in_conv, out_ready,
    output in_ready, out_valid, out_data, out_outlier, out_last
  );
endinterface

// File: rtl/stream_dequantizer_pipe.sv
// Streaming de-quantizer. One packed block is accepted per handshake and its
// fields are unpacked one per cycle, then pushed through a 3-stage pipeline:
//   S0 extract (field or escape-coded raw word) -> S1 add Mid -> S2 format.
// Ports:
//  clk, rst : clock, synchronous active-high reset
//  bus      : stream_dequantizer_pipe_if.slave (block in, word stream out)
//  busy     : FSM unpacking or any pipeline stage holding a word
module stream_dequantizer_pipe #(
  parameter int L2_WIDTH   = 512,
  parameter int SWIDTH     = 5,
  parameter int WORD_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int CNT_WIDTH  = 9
) (
  input  logic clk,
  input  logic rst,
  stream_dequantizer_pipe_if.slave bus,
  output logic busy
);
  localparam int PTR_WIDTH = $clog2(L2_WIDTH) + 1;
  localparam int EXPF_W    = WORD_WIDTH - 25;
  localparam int MANT_W    = 24;
  localparam int WIN_W     = 2 * WORD_WIDTH;
  localparam int PW        = $clog2(WORD_WIDTH);

  typedef enum logic {IDLE, UNPACK} state_t;

  // Every stage carries its block's settings so consecutive blocks never mix.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] val;
    logic [SWIDTH-1:0]     fw;
    logic                  outlier;
    logic                  last;
    logic                  conv;
    logic [WORD_WIDTH-1:0] mid;
    logic [EXP_WIDTH-1:0]  stepExp;
  } s0_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] val;
    logic                  outlier;
    logic                  last;
    logic                  conv;
    logic [EXP_WIDTH-1:0]  stepExp;
  } s1_t;

  state_t                state, stateNext;
  logic [L2_WIDTH-1:0]   blk;
  logic [SWIDTH-1:0]     fw;
  logic [CNT_WIDTH-1:0]  cntLeft;
  logic [WORD_WIDTH-1:0] mid;
  logic [EXP_WIDTH-1:0]  stepExp;
  logic                  conv;
  logic [PTR_WIDTH-1:0]  ptr;
  logic [2:0]            vldPipe;   // [0]=S0, [1]=S1, [2]=output register
  s0_t                   s0;
  s1_t                   s1;
  logic [WORD_WIDTH-1:0] outData;
  logic                  outOutlier, outLast;

  // Whole pipeline, FSM and pointer freeze while the output word is refused.
  logic advance, accept;
  assign advance     = !(vldPipe[2] && !bus.out_ready);
  assign bus.in_ready = (state == IDLE) && advance && !rst;
  assign accept      = bus.in_valid && bus.in_ready;

  // ---- S0: extraction. Shifting the whole block right makes bits past the
  // end read as zero; a 2-word window covers an escape raw word.
  logic [WIN_W-1:0]      win;
  logic [WORD_WIDTH-1:0] fMask, fld, raw;
  logic                  isEsc, isLast;
  logic [PTR_WIDTH-1:0]  ptrStep;

  assign win     = WIN_W'(blk >> ptr);
  assign fMask   = (WORD_WIDTH'(1) << fw) - WORD_WIDTH'(1);
  assign fld     = win[WORD_WIDTH-1:0] & fMask;
  assign isEsc   = (fw != '0) && (fld == fMask);
  assign raw     = WORD_WIDTH'(win >> fw);
  assign isLast  = (cntLeft == CNT_WIDTH'(1));
  assign ptrStep = isEsc ? PTR_WIDTH'(fw) + PTR_WIDTH'(WORD_WIDTH) : PTR_WIDTH'(fw);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (accept && bus.in_count != '0) stateNext = UNPACK;
      UNPACK: if (advance && isLast) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      blk     <= bus.in_block;
      fw      <= bus.in_field_w;
      cntLeft <= bus.in_count;
      mid     <= bus.in_mid;
      stepExp <= bus.in_step_exp;
      conv    <= bus.in_conv;
      ptr     <= '0;
    end else if (state == UNPACK && advance) begin
      ptr     <= ptr + ptrStep;
      cntLeft <= cntLeft - CNT_WIDTH'(1);
    end
  end

  // ---- S1: sign-extend the field and add Mid (escape words pass untouched).
  logic [WORD_WIDTH-1:0] s1Mask, sext, s1Val;
  logic                  s1Sign;

  assign s1Mask = (WORD_WIDTH'(1) << s0.fw) - WORD_WIDTH'(1);
  assign s1Sign = (s0.fw != '0) && s0.val[s0.fw - SWIDTH'(1)];
  assign sext   = s1Sign ? (s0.val | ~s1Mask) : s0.val;
  assign s1Val  = s0.outlier ? s0.val : (s0.conv ? s0.mid + sext : s0.val);

  // ---- S2: sign/magnitude, leading-one normalise, step exponent scaling.
  logic                  sgn;
  logic [WORD_WIDTH-1:0] mag, fmt, outWord;
  logic [PW-1:0]         lead;
  logic [EXPF_W-1:0]     expF;
  logic [MANT_W-1:0]     mant;

  assign sgn = s1.val[WORD_WIDTH-1];
  assign mag = sgn ? -s1.val : s1.val;

  always_comb begin
    lead = '0;
    for (int i = 0; i < WORD_WIDTH; i++)
      if (mag[i]) lead = PW'(i);
  end

  assign expF = EXPF_W'(WORD_WIDTH'(s1.stepExp) + WORD_WIDTH'(lead));
  // Move the leading one to the top bit, then keep the MANT_W bits under it.
  assign mant = MANT_W'((mag << (PW'(WORD_WIDTH - 1) - lead)) >> (WORD_WIDTH - 1 - MANT_W));
  assign fmt  = (mag == '0) ? '0 : {sgn, expF, mant};
  assign outWord = (s1.conv && !s1.outlier) ? fmt : s1.val;

  always_ff @(posedge clk) begin
    if (advance) begin
      s0.val     <= isEsc ? raw : fld;
      s0.fw      <= fw;
      s0.outlier <= isEsc;
      s0.last    <= isLast;
      s0.conv    <= conv;
      s0.mid     <= mid;
      s0.stepExp <= stepExp;
      s1.val     <= s1Val;
      s1.outlier <= s0.outlier;
      s1.last    <= s0.last;
      s1.conv    <= s0.conv;
      s1.stepExp <= s0.stepExp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vldPipe    <= '0;
      outData    <= '0;
      outOutlier <= 1'b0;
      outLast    <= 1'b0;
    end else if (advance) begin
      vldPipe <= {vldPipe[1:0], state == UNPACK};
      if (vldPipe[1]) begin
        outData    <= outWord;
        outOutlier <= s1.outlier;
        outLast    <= s1.last;
      end
    end
  end

  assign bus.out_valid   = vldPipe[2];
  assign bus.out_data    = outData;
  assign bus.out_outlier = outOutlier;
  assign bus.out_last    = outLast;
  assign busy            = (state != IDLE) || (|vldPipe);
endmodule

// File: tb/tb_stream_dequantizer_pipe.sv
// Directed bench for stream_dequantizer_pipe: hand-computed words are queued
// before each block is sent; a negedge monitor pops and compares every word
// transferred, while the main thread checks latency, stalls and reset.
module tb_stream_dequantizer_pipe;
  logic clk, rst, busy;

  stream_dequantizer_pipe_if #(.L2_WIDTH(512), .SWIDTH(5), .WORD_WIDTH(32),
                               .EXP_WIDTH(8), .CNT_WIDTH(9)) bus ();

  stream_dequantizer_pipe #(.L2_WIDTH(512), .SWIDTH(5), .WORD_WIDTH(32),
                            .EXP_WIDTH(8), .CNT_WIDTH(9)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCmp = 0, nBad = 0, cyc = 0, rxCount = 0;
  logic [63:0] expQ[$];
  int stampQ[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] expW(input logic o, input logic l, input logic [31:0] d);
    return {30'b0, o, l, d};
  endfunction

  always @(posedge clk) cyc++;

  // A word transfers on the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready) begin
      if (expQ.size() == 0) chk("unexpectedWord", {31'b0, bus.out_outlier, bus.out_data}, 64'hFFFF);
      else chk("word", expW(bus.out_outlier, bus.out_last, bus.out_data), expQ.pop_front());
      stampQ.push_back(cyc);
      rxCount++;
    end
  end

  task automatic sendBlock(input logic [511:0] b, input logic [4:0] w, input logic [8:0] c,
                           input logic [31:0] m, input logic [7:0] s, input logic cv);
    bit ok = 0;
    bus.in_valid = 1'b1; bus.in_block = b; bus.in_field_w = w; bus.in_count = c;
    bus.in_mid = m; bus.in_step_exp = s; bus.in_conv = cv;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("acceptTimeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk(tag, ok, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [511:0] b;
    int base;
    bit ok;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_block = '0; bus.in_field_w = '0; bus.in_count = '0;
    bus.in_mid = '0; bus.in_step_exp = '0; bus.in_conv = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstInReady", bus.in_ready, 0);
    chk("rstOutValid", bus.out_valid, 0);
    chk("rstOutData", bus.out_data, 0);
    chk("rstOutLastOutlier", {bus.out_last, bus.out_outlier}, 0);
    chk("rstBusy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("inReadyAfterRst", bus.in_ready, 1);
    @(posedge clk); #1;

    // 1) integer passthrough, latency 3 cycles after accept
    b = '0; b[11:0] = 12'h321;
    expQ.push_back(expW(0, 0, 32'h1));
    expQ.push_back(expW(0, 0, 32'h2));
    expQ.push_back(expW(0, 1, 32'h3));
    sendBlock(b, 5'd4, 9'd3, 32'h0, 8'h0, 1'b0);
    @(negedge clk); chk("lat1", bus.out_valid, 0);
    @(negedge clk); chk("lat2", bus.out_valid, 0);
    @(negedge clk); chk("lat3", bus.out_valid, 0);
    @(negedge clk); chk("latFirst", bus.out_valid, 1);
    waitDrain("drain1");

    // 2) float conversion: Mid, negative, zero, exponent wrap, field_w = 0
    b = '0; b[3:0] = 4'h3;
    expQ.push_back(expW(0, 1, 32'h0C300000));
    sendBlock(b, 5'd4, 9'd1, 32'h10, 8'd8, 1'b1);
    b = '0; b[3:0] = 4'hE;
    expQ.push_back(expW(0, 1, 32'h89000000));
    sendBlock(b, 5'd4, 9'd1, 32'h0, 8'd8, 1'b1);
    b = '0;
    expQ.push_back(expW(0, 1, 32'h0));
    sendBlock(b, 5'd4, 9'd1, 32'h0, 8'd8, 1'b1);
    expQ.push_back(expW(0, 1, 32'h8C000000));
    sendBlock(b, 5'd4, 9'd1, 32'hFFFFFFF0, 8'd8, 1'b1);
    expQ.push_back(expW(0, 1, 32'h02000000));
    sendBlock(b, 5'd4, 9'd1, 32'h10, 8'hFE, 1'b1);
    expQ.push_back(expW(0, 0, 32'h02400000));
    expQ.push_back(expW(0, 1, 32'h02400000));
    sendBlock({512{1'b1}}, 5'd0, 9'd2, 32'h5, 8'd0, 1'b1);
    waitDrain("drain2");

    // 3) escape-coded outlier
    b = '0; b[39:0] = {32'hDEADBEEF, 4'hF, 4'h5};
    expQ.push_back(expW(0, 0, 32'h5));
    expQ.push_back(expW(1, 1, 32'hDEADBEEF));
    sendBlock(b, 5'd4, 9'd2, 32'h0, 8'h0, 1'b0);
    waitDrain("drain3");

    // 4) backpressure: hold output for 5 cycles after the 2nd word
    b = '0; b[63:0] = 64'h1716151413121110;
    for (int i = 0; i < 8; i++) expQ.push_back(expW(0, i == 7, 32'h10 + i));
    base = rxCount;
    sendBlock(b, 5'd8, 9'd8, 32'h0, 8'h0, 1'b0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (rxCount >= base + 2) begin ok = 1; break; end
    end
    chk("stallReach", ok, 1);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stallValid", bus.out_valid, 1);
      chk("stallData", bus.out_data, 32'h12);
    end
    chk("stallBusy", busy, 1);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    waitDrain("drain4");
    chk("stallCount", rxCount - base, 8);

    // 5) back-to-back: float block, empty block, integer block
    base = rxCount;
    b = '0; b[7:0] = 8'h03;
    expQ.push_back(expW(0, 0, 32'h0C300000));
    expQ.push_back(expW(0, 1, 32'h0C000000));
    sendBlock(b, 5'd4, 9'd2, 32'h10, 8'd8, 1'b1);
    sendBlock({512{1'b1}}, 5'd4, 9'd0, 32'h10, 8'd8, 1'b1);
    b = '0; b[7:0] = 8'hA9;
    expQ.push_back(expW(0, 0, 32'h9));
    expQ.push_back(expW(0, 1, 32'hA));
    sendBlock(b, 5'd4, 9'd2, 32'h0, 8'h0, 1'b0);
    waitDrain("drain5");
    chk("b2bCount", rxCount - base, 4);
    if (stampQ.size() >= base + 4) chk("b2bGap", stampQ[base + 2] - stampQ[base + 1], 3);
    else chk("b2bStamps", stampQ.size(), base + 4);

    // 6) reset mid-block with three words in flight
    base = rxCount;
    bus.out_ready = 1'b0;
    b = '0; b[63:0] = 64'h0123456789ABCDEF;
    sendBlock(b, 5'd8, 9'd8, 32'h0, 8'h0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk); chk("inFlightValid", bus.out_valid, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midRstValid", bus.out_valid, 0);
    chk("midRstBusy", busy, 0);
    chk("midRstInReady", bus.in_ready, 0);
    @(posedge clk); #1 rst = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); chk("relInReady", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    chk("rstNoWords", rxCount - base, 0);
    chk("rstOutIdle", {bus.out_valid, busy}, 0);

    chk("leftover", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
